// File: rtl/bist_loopback_if.sv
// Control, functional-traffic and loopback bundle for bist_loopback.
interface bist_loopback_if #(
  parameter int unsigned TEST_CHANNELS = 70,
  parameter int unsigned ERR_W         = 16
);
  logic                     start;
  logic                     abort;
  logic [TEST_CHANNELS-1:0] input_channels;
  logic [TEST_CHANNELS-1:0] loop_channels;
  logic [TEST_CHANNELS-1:0] output_channels;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [ERR_W-1:0]         err_count;

  modport master (
    output start, abort, input_channels, loop_channels,
    input  output_channels, busy, done, pass, err_count
  );

  modport slave (
    input  start, abort, input_channels, loop_channels,
    output output_channels, busy, done, pass, err_count
  );
endinterface

// File: rtl/bist_loopback.sv
// LFSR loopback self-test with functional passthrough when idle/done.
// Optional first-failure capture ports: define BIST_ERR_CAPTURE_EN.
module bist_loopback #(
  parameter int unsigned TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int unsigned TEST_CASES    = 1000,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned ERR_W         = 16
) (
  input  logic clk,
  input  logic reset_n,
  bist_loopback_if.slave bus
`ifdef BIST_ERR_CAPTURE_EN
  ,
  output logic [31:0]              first_fail_idx,
  output logic [TEST_CHANNELS-1:0] first_fail_mask
`endif
);

  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY      = 32'h80200003;
  localparam logic [31:0] LAST_CASE = 32'(TEST_CASES - 1);
  localparam logic [31:0] LAT       = 32'(LATENCY);
  localparam logic [TEST_CHANNELS+31:0] SEED_EXT = {{TEST_CHANNELS{1'b0}}, SEED_EFF};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] n);
    return (n >> 1) ^ (n[0] ? POLY : 32'h0);
  endfunction

  // Lower bits of {pattern, lfsr} equal ((pattern << 32) | lfsr) truncated.
  function automatic logic [TEST_CHANNELS-1:0] pat_shift(input logic [TEST_CHANNELS-1:0] p,
                                                         input logic [31:0] l);
    logic [TEST_CHANNELS+31:0] cat;
    cat = {p, l};
    return cat[TEST_CHANNELS-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [TEST_CHANNELS-1:0] gen_pat_q, gen_pat_d, chk_pat_q, chk_pat_d;
  logic [31:0]              gen_lfsr_q, gen_lfsr_d, chk_lfsr_q, chk_lfsr_d;
  logic [31:0]              sent_q, sent_d, checked_q, checked_d, wait_q, wait_d;
  logic [ERR_W-1:0]         err_q, err_d;
  logic                     busy, cmp_en, mismatch, start_ok;
`ifdef BIST_ERR_CAPTURE_EN
  logic [31:0]              ff_idx_q, ff_idx_d;
  logic [TEST_CHANNELS-1:0] ff_mask_q, ff_mask_d;
  logic                     ff_seen_q, ff_seen_d;
`endif

  always_comb begin
    state_d    = state_q;
    gen_pat_d  = gen_pat_q;
    gen_lfsr_d = gen_lfsr_q;
    chk_pat_d  = chk_pat_q;
    chk_lfsr_d = chk_lfsr_q;
    sent_d     = sent_q;
    checked_d  = checked_q;
    wait_d     = wait_q;
    err_d      = err_q;
`ifdef BIST_ERR_CAPTURE_EN
    ff_idx_d   = ff_idx_q;
    ff_mask_d  = ff_mask_q;
    ff_seen_d  = ff_seen_q;
`endif
    busy     = (state_q == RUN) || (state_q == DRAIN);
    cmp_en   = busy && (wait_q == LAT);
    mismatch = (bus.loop_channels != chk_pat_q);
    start_ok = bus.start && !bus.abort && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d    = RUN;
          gen_pat_d  = SEED_EXT[TEST_CHANNELS-1:0];
          gen_lfsr_d = lfsr_next(SEED_EFF);
          chk_pat_d  = SEED_EXT[TEST_CHANNELS-1:0];
          chk_lfsr_d = lfsr_next(SEED_EFF);
          sent_d     = '0;
          checked_d  = '0;
          wait_d     = '0;
          err_d      = '0;
`ifdef BIST_ERR_CAPTURE_EN
          ff_idx_d   = '0;
          ff_mask_d  = '0;
          ff_seen_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        gen_pat_d  = pat_shift(gen_pat_q, gen_lfsr_q);
        gen_lfsr_d = lfsr_next(gen_lfsr_q);
        sent_d     = sent_q + 32'd1;
        if (sent_q == LAST_CASE) state_d = DRAIN;
      end
      default: ;
    endcase

    // Completion of checking overrides the RUN->DRAIN step, which skips DRAIN at zero latency.
    if (cmp_en) begin
      if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
`ifdef BIST_ERR_CAPTURE_EN
      if (mismatch && !ff_seen_q) begin
        ff_idx_d  = checked_q;
        ff_mask_d = bus.loop_channels ^ chk_pat_q;
        ff_seen_d = 1'b1;
      end
`endif
      chk_pat_d  = pat_shift(chk_pat_q, chk_lfsr_q);
      chk_lfsr_d = lfsr_next(chk_lfsr_q);
      checked_d  = checked_q + 32'd1;
      if (checked_q == LAST_CASE) state_d = DONE;
    end

    if (busy && (wait_q != LAT)) wait_d = wait_q + 32'd1;
    if (busy && bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gen_pat_q  <= '0;
      gen_lfsr_q <= '0;
      chk_pat_q  <= '0;
      chk_lfsr_q <= '0;
      sent_q     <= '0;
      checked_q  <= '0;
      wait_q     <= '0;
      err_q      <= '0;
`ifdef BIST_ERR_CAPTURE_EN
      ff_idx_q   <= '0;
      ff_mask_q  <= '0;
      ff_seen_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gen_pat_q  <= gen_pat_d;
      gen_lfsr_q <= gen_lfsr_d;
      chk_pat_q  <= chk_pat_d;
      chk_lfsr_q <= chk_lfsr_d;
      sent_q     <= sent_d;
      checked_q  <= checked_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
`ifdef BIST_ERR_CAPTURE_EN
      ff_idx_q   <= ff_idx_d;
      ff_mask_q  <= ff_mask_d;
      ff_seen_q  <= ff_seen_d;
`endif
    end
  end

  always_comb begin
    bus.output_channels = bus.input_channels;
    if (state_q == RUN)        bus.output_channels = gen_pat_q;
    else if (state_q == DRAIN) bus.output_channels = '0;
  end

  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_q == '0);
  assign bus.err_count = err_q;
`ifdef BIST_ERR_CAPTURE_EN
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_mask = ff_mask_q;
`endif

endmodule

// File: tb/tb_bist_loopback.sv
// Scoreboard bench: runs push expected completion records, per-DUT monitors check them on done.
module tb_bist_loopback;
  localparam int unsigned CW = 70;
  localparam logic [CW-1:0] CASE0 = 70'h0_deadbeef;
  localparam logic [CW-1:0] CASE1 = 70'h00_deadbeef_ef76df74;
  localparam logic [CW-1:0] CASE2 = 70'h2f_ef76df74_77bb6fba;
  localparam logic [CW-1:0] IN_A  = 70'h2a_5555aaaa_12345678;
  localparam logic [CW-1:0] IN_B  = 70'h15_0f0f0f0f_cafef00d;

  typedef struct {
    logic [15:0] err;
    logic        pass;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  exp_t        qa[$], qb[$], qc[$];
  int unsigned a_t0 = 0, b_t0 = 0, c_t0 = 0;
  logic        a_flip_en = 1'b0;
  logic        a_dp = 1'b0, b_dp = 1'b0, c_dp = 1'b0;
  logic [CW-1:0] a_d1, a_d2, b_d1, b_d2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bist_loopback_if #(.TEST_CHANNELS(CW), .ERR_W(16)) ia ();
  bist_loopback_if #(.TEST_CHANNELS(CW), .ERR_W(4))  ib ();
  bist_loopback_if #(.TEST_CHANNELS(CW), .ERR_W(16)) ic ();

`ifdef BIST_ERR_CAPTURE_EN
  logic [31:0] a_ffi, b_ffi, c_ffi;
  logic [CW-1:0] a_ffm, b_ffm, c_ffm;
`endif

  bist_loopback #(.TEST_CHANNELS(CW), .SEED(32'hdeadbeef), .TEST_CASES(1000), .LATENCY(2), .ERR_W(16))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(ia)
`ifdef BIST_ERR_CAPTURE_EN
      , .first_fail_idx(a_ffi), .first_fail_mask(a_ffm)
`endif
    );
  bist_loopback #(.TEST_CHANNELS(CW), .SEED(32'hdeadbeef), .TEST_CASES(20), .LATENCY(2), .ERR_W(4))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ib)
`ifdef BIST_ERR_CAPTURE_EN
      , .first_fail_idx(b_ffi), .first_fail_mask(b_ffm)
`endif
    );
  bist_loopback #(.TEST_CHANNELS(CW), .SEED(32'hdeadbeef), .TEST_CASES(1), .LATENCY(0), .ERR_W(16))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(ic)
`ifdef BIST_ERR_CAPTURE_EN
      , .first_fail_idx(c_ffi), .first_fail_mask(c_ffm)
`endif
    );

  // Two-cycle return paths; A can corrupt bit 3 of case 5, B returns inverted data.
  always @(posedge clk) begin
    a_d1 <= ia.output_channels;
    a_d2 <= a_d1;
    b_d1 <= ib.output_channels;
    b_d2 <= b_d1;
  end
  assign ia.loop_channels = a_d2 ^ ((a_flip_en && (cyc == a_t0 + 7)) ? CW'(8) : '0);
  assign ib.loop_channels = ~b_d2;
  assign ic.loop_channels = ic.output_channels;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input logic [15:0] err, input logic pass);
    chk({tag, "_err_count"}, 128'(err), 128'(e.err));
    chk({tag, "_pass"}, 128'(pass), 128'(e.pass));
    chk({tag, "_done_cycle"}, 128'(cyc), 128'(e.cyc));
  endtask

  task automatic mon_none(input string tag);
    total++;
    bad++;
    $display("FAIL %s_unexpected_done actual=done required=no_done (cycle %0d)", tag, cyc);
  endtask

  always @(negedge clk) begin
    if (ia.done && !a_dp) begin
      if (qa.size() == 0) mon_none("a");
      else mon_cmp("a", qa.pop_front(), 16'(ia.err_count), ia.pass);
    end
    if (ib.done && !b_dp) begin
      if (qb.size() == 0) mon_none("b");
      else mon_cmp("b", qb.pop_front(), 16'(ib.err_count), ib.pass);
    end
    if (ic.done && !c_dp) begin
      if (qc.size() == 0) mon_none("c");
      else mon_cmp("c", qc.pop_front(), 16'(ic.err_count), ic.pass);
    end
    a_dp <= ia.done;
    b_dp <= ib.done;
    c_dp <= ic.done;
  end

  task automatic wait_drained(input string tag, input int which, input int unsigned budget);
    int unsigned left;
    left = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      left = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
      if (left == 0) break;
      @(negedge clk);
    end
    left = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
    chk({tag, "_pending_after_budget"}, 128'(left), 128'(0));
    if (which == 0) qa.delete();
    else if (which == 1) qb.delete();
    else qc.delete();
  endtask

  task automatic pulse_a();
    @(negedge clk) ia.start = 1'b1;
    @(negedge clk) ia.start = 1'b0;
    a_t0 = cyc;
  endtask

  task automatic push_a(input logic [15:0] err, input logic pass);
    exp_t e;
    e.err = err; e.pass = pass; e.cyc = a_t0 + 1002;
    qa.push_back(e);
  endtask

  initial begin
    exp_t e;
    ia.start = 0; ia.abort = 0; ia.input_channels = IN_A;
    ib.start = 0; ib.abort = 0; ib.input_channels = IN_A;
    ic.start = 0; ic.abort = 0; ic.input_channels = IN_A;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(ia.busy), 128'(0));
    chk("rst_done", 128'(ia.done), 128'(0));
    chk("rst_pass", 128'(ia.pass), 128'(0));
    chk("rst_err", 128'(ia.err_count), 128'(0));
    chk("rst_passthrough", 128'(ia.output_channels), 128'(IN_A));
    reset_n = 1'b1;

    // Run 1: single bit-3 error on case 5.
    a_flip_en = 1'b1;
    pulse_a();
    push_a(16'd1, 1'b0);
    chk("r1_busy", 128'(ia.busy), 128'(1));
    chk("r1_case0", 128'(ia.output_channels), 128'(CASE0));
    @(negedge clk) chk("r1_case1", 128'(ia.output_channels), 128'(CASE1));
    @(negedge clk) chk("r1_case2", 128'(ia.output_channels), 128'(CASE2));
    wait_drained("r1", 0, 1100);
    @(negedge clk);
    chk("r1_done_hold", 128'(ia.done), 128'(1));
    chk("r1_busy_low", 128'(ia.busy), 128'(0));
    ia.input_channels = IN_B;
    #1 chk("r1_done_passthrough", 128'(ia.output_channels), 128'(IN_B));
`ifdef BIST_ERR_CAPTURE_EN
    chk("r1_first_fail_idx", 128'(a_ffi), 128'(5));
    chk("r1_first_fail_mask", 128'(a_ffm), 128'(8));
`endif

    // Run 2: restart from DONE, clean path, second start mid-run ignored.
    a_flip_en = 1'b0;
    pulse_a();
    push_a(16'd0, 1'b1);
    chk("r2_err_cleared", 128'(ia.err_count), 128'(0));
    chk("r2_done_cleared", 128'(ia.done), 128'(0));
    repeat (490) @(negedge clk);
    ia.start = 1'b1;
    @(negedge clk) ia.start = 1'b0;
    wait_drained("r2", 0, 1100);
`ifdef BIST_ERR_CAPTURE_EN
    chk("r2_first_fail_idx", 128'(a_ffi), 128'(0));
    chk("r2_first_fail_mask", 128'(a_ffm), 128'(0));
`endif

    // Run 3: abort at case 300 keeps err_count, returns to IDLE.
    a_flip_en = 1'b1;
    pulse_a();
    repeat (300) @(negedge clk);
    ia.abort = 1'b1;
    @(negedge clk) ia.abort = 1'b0;
    chk("abort_busy", 128'(ia.busy), 128'(0));
    chk("abort_done", 128'(ia.done), 128'(0));
    chk("abort_pass", 128'(ia.pass), 128'(0));
    chk("abort_err_kept", 128'(ia.err_count), 128'(1));
    chk("abort_passthrough", 128'(ia.output_channels), 128'(IN_B));
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", 128'(ia.done), 128'(0));

    // Run 4: reset asserted during DRAIN.
    pulse_a();
    repeat (1000) @(negedge clk);
    chk("drain_busy", 128'(ia.busy), 128'(1));
    chk("drain_output_zero", 128'(ia.output_channels), 128'(0));
    chk("drain_err", 128'(ia.err_count), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(ia.busy), 128'(0));
    chk("midrst_done", 128'(ia.done), 128'(0));
    chk("midrst_err", 128'(ia.err_count), 128'(0));
    chk("midrst_passthrough", 128'(ia.output_channels), 128'(IN_B));
    a_flip_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // DUT B: inverted return, 20 cases, 4-bit counter saturates.
    @(negedge clk) ib.start = 1'b1;
    @(negedge clk) ib.start = 1'b0;
    b_t0 = cyc;
    e.err = 16'hF; e.pass = 1'b0; e.cyc = b_t0 + 22;
    qb.push_back(e);
    wait_drained("sat", 1, 60);

    // DUT C: zero latency, single case.
    @(negedge clk) ic.start = 1'b1;
    @(negedge clk) ic.start = 1'b0;
    c_t0 = cyc;
    e.err = 16'h0; e.pass = 1'b1; e.cyc = c_t0 + 1;
    qc.push_back(e);
    chk("lat0_busy", 128'(ic.busy), 128'(1));
    chk("lat0_case0", 128'(ic.output_channels), 128'(CASE0));
    @(negedge clk);
    chk("lat0_busy_low", 128'(ic.busy), 128'(0));
    wait_drained("lat0", 2, 10);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
